// File: rtl/sorting_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sorting_pkg
//  Description : Shared types and helpers for the sorting_stream packet
//                sorter: FSM state encoding, address-width formula and the
//                word-ordering predicate used by the in-place sort.
//  Revision    : 1.0 - initial release
// ============================================================================
package sorting_pkg;

    typedef enum logic [2:0] {
        IDLE_S    = 3'd0,
        LOAD_S    = 3'd1,
        SORT_RD_S = 3'd2,
        SORT_WR_S = 3'd3,
        SEND_S    = 3'd4
    } state_t;

    // Width of the compare operands. Callers extend DWIDTH-bit words to this
    // width (sign- or zero-extended), which supports DWIDTH up to 64.
    localparam int CMP_W = 65;

    // Counter/index width: must hold the value MAX_PKT_LEN itself.
    function automatic int calc_aw(input int max_len);
        return $clog2(max_len) + 1;
    endfunction

    // True when a (lower address) and b (higher address) must be exchanged.
    // Equal words return 0, which keeps the sort stable.
    function automatic logic out_of_order(
        input logic [CMP_W-1:0] a,
        input logic [CMP_W-1:0] b,
        input logic             desc,
        input logic             sgn
    );
        logic gt;
        logic lt;
        if (sgn) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        return desc ? lt : gt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sorting_dpram.sv
`default_nettype none
// ============================================================================
//  Module      : sorting_dpram
//  Description : True dual-port RAM, one clock, registered (1-cycle) read on
//                both ports, write-first behaviour on each port.
//  Ports       : clk_i/arst_i          clock, async active-high reset (read
//                                      registers only; array is not reset)
//                we_a/addr_a/wd_a/rd_a port A write enable, address, data
//                we_b/addr_b/wd_b/rd_b port B write enable, address, data
//  Revision    : 1.0 - initial release
// ============================================================================
module sorting_dpram #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 10,
    parameter int DEPTH  = 1 << AWIDTH
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              we_a,
    input  logic [AWIDTH-1:0] addr_a,
    input  logic [DWIDTH-1:0] wd_a,
    output logic [DWIDTH-1:0] rd_a,
    input  logic              we_b,
    input  logic [AWIDTH-1:0] addr_b,
    input  logic [DWIDTH-1:0] wd_b,
    output logic [DWIDTH-1:0] rd_b
);

    logic [DWIDTH-1:0] r_mem [DEPTH];

    // Both write ports in one process; the sorter never writes the same
    // address on both ports in one cycle.
    always_ff @(posedge clk_i) begin
        if (we_a) r_mem[addr_a] <= wd_a;
        if (we_b) r_mem[addr_b] <= wd_b;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rd_a <= '0;
            rd_b <= '0;
        end else begin
            rd_a <= we_a ? wd_a : r_mem[addr_a];
            rd_b <= we_b ? wd_b : r_mem[addr_b];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sorting_stream.sv
`default_nettype none
// ============================================================================
//  Module      : sorting_stream
//  Description : Avalon-ST packet sorter. Buffers one packet into a dual-port
//                RAM, sorts it in place by odd-even transposition (with early
//                exit after two swap-free passes) and streams it out.
//  Ports       : clk_i, arst_i         clock, async active-high reset
//                snk_*                 Avalon-ST sink (data/sop/eop/valid/ready)
//                src_*                 Avalon-ST source, registered, held
//                                      stable while valid & !ready
//                ovf_o                 one-cycle pulse: packet was truncated
//  Revision    : 1.0 - initial release
// ============================================================================
module sorting_stream
    import sorting_pkg::*;
#(
    parameter int DWIDTH      = 16,
    parameter int MAX_PKT_LEN = 1024,
    parameter int DESCENDING  = 0,
    parameter int SIGNED_CMP  = 0
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_valid_o,
    input  logic              src_ready_i,
    output logic              ovf_o
);

    localparam int AW  = calc_aw(MAX_PKT_LEN);
    localparam int RAW = AW - 1;               // RAM index width
    localparam int EXT = CMP_W - DWIDTH;
    localparam logic [AW-1:0] c_max_len = AW'(MAX_PKT_LEN);

    state_t             r_state;
    logic [AW-1:0]      r_len;
    logic [AW-1:0]      r_k;
    logic [AW-1:0]      r_pass;
    logic [AW-1:0]      r_rd_addr;
    logic               r_trunc;
    logic               r_swapped;
    logic               r_prev_quiet;
    logic               r_pend;
    logic               r_pend_sop;
    logic               r_pend_eop;
    logic               r_buf_valid;
    logic               r_buf_sop;
    logic               r_buf_eop;
    logic [DWIDTH-1:0]  r_buf_data;
    logic               r_snk_ready;
    logic               r_src_valid;
    logic               r_src_sop;
    logic               r_src_eop;
    logic [DWIDTH-1:0]  r_src_data;
    logic               r_ovf;

    logic               w_we_a;
    logic               w_we_b;
    logic [RAW-1:0]     w_addr_a;
    logic [RAW-1:0]     w_addr_b;
    logic [DWIDTH-1:0]  w_wd_a;
    logic [DWIDTH-1:0]  w_wd_b;
    logic [DWIDTH-1:0]  w_rd_a;
    logic [DWIDTH-1:0]  w_rd_b;

    logic               w_snk_beat;
    logic               w_src_pop;
    logic               w_at_max;
    logic               w_load_wr;
    logic [AW-1:0]      w_k1;
    logic               w_pair;
    logic               w_sgn;
    logic [CMP_W-1:0]   w_a_ext;
    logic [CMP_W-1:0]   w_b_ext;
    logic               w_swap;
    logic [1:0]         w_occ;
    logic               w_issue;
    logic               w_rd_sop;
    logic               w_rd_eop;

    assign snk_ready_o         = r_snk_ready;
    assign src_valid_o         = r_src_valid;
    assign src_data_o          = r_src_data;
    assign src_startofpacket_o = r_src_sop;
    assign src_endofpacket_o   = r_src_eop;
    assign ovf_o               = r_ovf;

    assign w_snk_beat = snk_valid_i & r_snk_ready;
    assign w_src_pop  = r_src_valid & src_ready_i;
    assign w_at_max   = (r_len == c_max_len);

    // Beats past the capacity are dropped; SOP always lands at address 0.
    assign w_load_wr  = w_snk_beat &
                        (((r_state == IDLE_S) & snk_startofpacket_i) |
                         ((r_state == LOAD_S) & (snk_startofpacket_i | ~w_at_max)));

    assign w_k1   = r_k + AW'(1);
    assign w_pair = (w_k1 < r_len);

    assign w_sgn   = (SIGNED_CMP != 0);
    assign w_a_ext = {{EXT{w_sgn & w_rd_a[DWIDTH-1]}}, w_rd_a};
    assign w_b_ext = {{EXT{w_sgn & w_rd_b[DWIDTH-1]}}, w_rd_b};
    assign w_swap  = out_of_order(w_a_ext, w_b_ext, DESCENDING != 0, w_sgn);

    // Prefetch credit: output register + skid entry + read in flight never
    // exceed two words, so a landing read always has somewhere to go.
    assign w_occ    = 2'(r_src_valid) + 2'(r_buf_valid) + 2'(r_pend);
    assign w_issue  = (r_state == SEND_S) & (r_rd_addr < r_len) &
                      ((w_occ - 2'(w_src_pop)) < 2'd2);
    assign w_rd_sop = (r_rd_addr == '0);
    assign w_rd_eop = (r_rd_addr == r_len - AW'(1));

    always_comb begin
        w_we_a   = 1'b0;
        w_we_b   = 1'b0;
        w_addr_a = r_rd_addr[RAW-1:0];
        w_addr_b = w_k1[RAW-1:0];
        w_wd_a   = snk_data_i;
        w_wd_b   = w_rd_a;
        case (r_state)
            IDLE_S, LOAD_S: begin
                w_we_a   = w_load_wr;
                w_addr_a = snk_startofpacket_i ? '0 : r_len[RAW-1:0];
            end
            SORT_RD_S: begin
                w_addr_a = r_k[RAW-1:0];
            end
            SORT_WR_S: begin
                // Exchange the pair: each port writes the other's word.
                w_we_a   = w_swap;
                w_we_b   = w_swap;
                w_addr_a = r_k[RAW-1:0];
                w_wd_a   = w_rd_b;
            end
            default: ;
        endcase
    end

    sorting_dpram #(
        .DWIDTH (DWIDTH),
        .AWIDTH (RAW),
        .DEPTH  (MAX_PKT_LEN)
    ) u_ram (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .we_a   (w_we_a),
        .addr_a (w_addr_a),
        .wd_a   (w_wd_a),
        .rd_a   (w_rd_a),
        .we_b   (w_we_b),
        .addr_b (w_addr_b),
        .wd_b   (w_wd_b),
        .rd_b   (w_rd_b)
    );

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state      <= IDLE_S;
            r_len        <= '0;
            r_k          <= '0;
            r_pass       <= '0;
            r_rd_addr    <= '0;
            r_trunc      <= 1'b0;
            r_swapped    <= 1'b0;
            r_prev_quiet <= 1'b0;
            r_pend       <= 1'b0;
            r_pend_sop   <= 1'b0;
            r_pend_eop   <= 1'b0;
            r_buf_valid  <= 1'b0;
            r_buf_sop    <= 1'b0;
            r_buf_eop    <= 1'b0;
            r_buf_data   <= '0;
            r_snk_ready  <= 1'b0;
            r_src_valid  <= 1'b0;
            r_src_sop    <= 1'b0;
            r_src_eop    <= 1'b0;
            r_src_data   <= '0;
            r_ovf        <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            case (r_state)
                IDLE_S, LOAD_S: begin
                    r_snk_ready  <= 1'b1;
                    // Sort bookkeeping is parked at its start values so the
                    // EOP beat can hand over straight to SORT.
                    r_k          <= '0;
                    r_pass       <= '0;
                    r_swapped    <= 1'b0;
                    r_prev_quiet <= 1'b0;
                    if (w_snk_beat && (snk_startofpacket_i || r_state == LOAD_S)) begin
                        if (snk_startofpacket_i) begin
                            r_len   <= AW'(1);
                            r_trunc <= 1'b0;
                        end else if (w_at_max) begin
                            r_trunc <= 1'b1;
                        end else begin
                            r_len   <= r_len + AW'(1);
                        end
                        if (snk_endofpacket_i) begin
                            r_state     <= SORT_RD_S;
                            r_snk_ready <= 1'b0;
                            r_ovf       <= ~snk_startofpacket_i & (r_trunc | w_at_max);
                        end else begin
                            r_state     <= LOAD_S;
                        end
                    end
                end

                SORT_RD_S: begin
                    if (w_pair) begin
                        r_state <= SORT_WR_S;
                    end else if ((!r_swapped && r_prev_quiet) ||
                                 (r_pass + AW'(1) == r_len)) begin
                        r_state   <= SEND_S;
                        r_rd_addr <= '0;
                    end else begin
                        // Next pass starts on the opposite parity.
                        r_pass       <= r_pass + AW'(1);
                        r_k          <= {{(AW-1){1'b0}}, ~r_pass[0]};
                        r_prev_quiet <= ~r_swapped;
                        r_swapped    <= 1'b0;
                    end
                end

                SORT_WR_S: begin
                    if (w_swap) r_swapped <= 1'b1;
                    r_k     <= r_k + AW'(2);
                    r_state <= SORT_RD_S;
                end

                SEND_S: begin
                    r_snk_ready <= 1'b0;
                    if (w_issue) r_rd_addr <= r_rd_addr + AW'(1);
                    r_pend     <= w_issue;
                    r_pend_sop <= w_rd_sop;
                    r_pend_eop <= w_rd_eop;

                    if (!r_src_valid || src_ready_i) begin
                        if (r_buf_valid) begin
                            r_src_data  <= r_buf_data;
                            r_src_sop   <= r_buf_sop;
                            r_src_eop   <= r_buf_eop;
                            r_src_valid <= 1'b1;
                            r_buf_valid <= r_pend;
                            r_buf_data  <= w_rd_a;
                            r_buf_sop   <= r_pend_sop;
                            r_buf_eop   <= r_pend_eop;
                        end else if (r_pend) begin
                            r_src_data  <= w_rd_a;
                            r_src_sop   <= r_pend_sop;
                            r_src_eop   <= r_pend_eop;
                            r_src_valid <= 1'b1;
                        end else begin
                            r_src_valid <= 1'b0;
                            r_src_sop   <= 1'b0;
                            r_src_eop   <= 1'b0;
                        end
                    end else if (r_pend) begin
                        r_buf_data  <= w_rd_a;
                        r_buf_sop   <= r_pend_sop;
                        r_buf_eop   <= r_pend_eop;
                        r_buf_valid <= 1'b1;
                    end

                    if (w_src_pop && r_src_eop) begin
                        r_state     <= IDLE_S;
                        r_snk_ready <= 1'b1;
                    end
                end

                default: r_state <= IDLE_S;
            endcase
        end
    end

endmodule
`default_nettype wire
